// File: rtl/cpu_pkg.sv
// Shared encodings for the 65C02 address/ALU datapath: ABL/ABH microcode selects and ALU codes.
package cpu_pkg;

    // ABL base select, abl_op[3:2]
    localparam logic [1:0] AblBaseHold = 2'b00;
    localparam logic [1:0] AblBasePcl  = 2'b01;
    localparam logic [1:0] AblBaseAhl  = 2'b10;
    localparam logic [1:0] AblBaseDbl  = 2'b11;

    // ABL offset select, abl_op[1:0]
    localparam logic [1:0] AblOffZero  = 2'b00;
    localparam logic [1:0] AblOffReg   = 2'b01;
    localparam logic [1:0] AblOffDbl   = 2'b10;
    localparam logic [1:0] AblOffFf    = 2'b11;

    // ABH base select, abh_op[1:0]
    localparam logic [1:0] AbhBaseHold = 2'b00;
    localparam logic [1:0] AbhBasePch  = 2'b01;
    localparam logic [1:0] AbhBaseDbl  = 2'b10;
    localparam logic [1:0] AbhBaseZero = 2'b11;

    // ALU function, alu_op[4:2]
    localparam logic [2:0] AluOr   = 3'd0;
    localparam logic [2:0] AluAnd  = 3'd1;
    localparam logic [2:0] AluEor  = 3'd2;
    localparam logic [2:0] AluAdd  = 3'd3;
    localparam logic [2:0] AluSub  = 3'd4;
    localparam logic [2:0] AluPass = 3'd5;
    localparam logic [2:0] AluShl  = 3'd6;
    localparam logic [2:0] AluShr  = 3'd7;

endpackage

// File: rtl/dp_alu.sv
// Combinational 8-bit ALU for the 65C02 datapath.
// Optional decimal-mode ADD/SUB is enabled by defining ALU_BCD_EN.
module dp_alu
    import cpu_pkg::*;
(
    input  logic [4:0] alu_op,
    input  logic       alu_ci,
    input  logic       alu_si,
    input  logic [7:0] reg_r,
    input  logic [7:0] alu_m,
    input  logic       dec,
    output logic [7:0] alu_out,
    output logic       alu_co,
    output logic       alu_v
);

    logic [2:0] fn;
    logic [7:0] src;
    logic [7:0] opb;
    logic [8:0] sum;

    assign fn  = alu_op[4:2];
    assign src = alu_op[0] ? reg_r : alu_m;
    assign opb = (fn == AluSub) ? ~alu_m : alu_m;
    assign sum = {1'b0, reg_r} + {1'b0, opb} + {8'b0, alu_ci};

`ifdef ALU_BCD_EN
    logic [5:0] bcd_lo;
    logic [5:0] bcd_hi;
    logic [4:0] bin_lo;
    logic       bcd_hc;

    always_comb begin
        bcd_lo = {2'b0, reg_r[3:0]} + {2'b0, alu_m[3:0]} + {5'b0, alu_ci};
        if (bcd_lo > 6'd9) begin
            bcd_lo = bcd_lo + 6'd6;
        end
        bcd_hc = (bcd_lo > 6'd15);
        bcd_hi = {2'b0, reg_r[7:4]} + {2'b0, alu_m[7:4]} + {5'b0, bcd_hc};
        if (bcd_hi > 6'd9) begin
            bcd_hi = bcd_hi + 6'd6;
        end
        // Binary half-carry of the subtract tells whether the low nibble borrowed.
        bin_lo = {1'b0, reg_r[3:0]} + {1'b0, opb[3:0]} + {4'b0, alu_ci};
    end

    logic unused_alu;
    assign unused_alu = alu_op[1];
`else
    logic unused_alu;
    assign unused_alu = ^{alu_op[1], dec};
`endif

    always_comb begin
        alu_out = 8'h00;
        alu_co  = 1'b0;
        alu_v   = 1'b0;
        unique case (fn)
            AluOr:   alu_out = reg_r | alu_m;
            AluAnd:  alu_out = reg_r & alu_m;
            AluEor:  alu_out = reg_r ^ alu_m;
            AluAdd, AluSub: begin
                alu_out = sum[7:0];
                alu_co  = sum[8];
                alu_v   = (reg_r[7] == opb[7]) & (sum[7] != reg_r[7]);
`ifdef ALU_BCD_EN
                if (dec && fn == AluAdd) begin
                    alu_out = {bcd_hi[3:0], bcd_lo[3:0]};
                    alu_co  = (bcd_hi > 6'd15);
                end else if (dec) begin
                    alu_out[3:0] = bin_lo[4] ? sum[3:0] : sum[3:0] - 4'd6;
                    alu_out[7:4] = sum[8] ? sum[7:4] : sum[7:4] - 4'd6;
                end
`endif
            end
            AluPass: alu_out = alu_m;
            AluShl: begin
                alu_out = {src[6:0], alu_si};
                alu_co  = src[7];
            end
            AluShr: begin
                alu_out = {alu_si, src[7:1]};
                alu_co  = src[0];
            end
            default: alu_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// 65C02 address/ALU datapath: combinational ABL/ABH generators with hold registers, plus ALU.
// Define ALU_BCD_EN to enable decimal-mode ADD/SUB in the ALU.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] abl_op,
    input  logic       abl_ci,
    input  logic [2:0] abh_op,
    input  logic       abh_ff,
    input  logic [7:0] pcl,
    input  logic [7:0] pch,
    input  logic [7:0] ahl,
    input  logic [7:0] dbl,
    input  logic [7:0] reg_r,
    input  logic [4:0] alu_op,
    input  logic       alu_ci,
    input  logic       alu_si,
    input  logic [7:0] alu_m,
    input  logic       dec,
    output logic [7:0] abl,
    output logic [7:0] abh,
    output logic       abl_co,
    output logic [7:0] alu_out,
    output logic       alu_co,
    output logic       alu_v
);

    logic [7:0] abl_q;
    logic [7:0] abh_q;
    logic [7:0] abl_base;
    logic [7:0] abl_off;
    logic [8:0] abl_sum;
    logic [7:0] abh_base;

    always_comb begin
        abl_base = abl_q;
        unique case (abl_op[3:2])
            AblBaseHold: abl_base = abl_q;
            AblBasePcl:  abl_base = pcl;
            AblBaseAhl:  abl_base = ahl;
            AblBaseDbl:  abl_base = dbl;
            default:     abl_base = abl_q;
        endcase

        abl_off = 8'h00;
        unique case (abl_op[1:0])
            AblOffZero: abl_off = 8'h00;
            AblOffReg:  abl_off = reg_r;
            AblOffDbl:  abl_off = dbl;
            AblOffFf:   abl_off = 8'hFF;
            default:    abl_off = 8'h00;
        endcase

        abh_base = abh_q;
        unique case (abh_op[1:0])
            AbhBaseHold: abh_base = abh_q;
            AbhBasePch:  abh_base = pch;
            AbhBaseDbl:  abh_base = dbl;
            AbhBaseZero: abh_base = 8'h00;
            default:     abh_base = abh_q;
        endcase
    end

    assign abl_sum = {1'b0, abl_base} + {1'b0, abl_off} + {8'b0, abl_ci};
    assign abl     = abl_sum[7:0];
    assign abl_co  = abl_sum[8];
    // Vector page forcing ignores any page-cross carry.
    assign abh     = abh_ff ? 8'hFF : abh_base + {7'b0, abh_op[2] & abl_co};

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            abl_q <= 8'h00;
            abh_q <= 8'h00;
        end else begin
            abl_q <= abl;
            abh_q <= abh;
        end
    end

    dp_alu u_alu (
        .alu_op  (alu_op),
        .alu_ci  (alu_ci),
        .alu_si  (alu_si),
        .reg_r   (reg_r),
        .alu_m   (alu_m),
        .dec     (dec),
        .alu_out (alu_out),
        .alu_co  (alu_co),
        .alu_v   (alu_v)
    );

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: ALU vector table, address corner sequences, random vs model.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       RST;
    logic [3:0] abl_op;
    logic       abl_ci;
    logic [2:0] abh_op;
    logic       abh_ff;
    logic [7:0] pcl, pch, ahl, dbl, reg_r;
    logic [4:0] alu_op;
    logic       alu_ci, alu_si;
    logic [7:0] alu_m;
    logic       dec;
    logic [7:0] abl, abh, alu_out;
    logic       abl_co, alu_co, alu_v;

    int checks = 0;
    int errors = 0;

    // Model of the address hold registers.
    int held_l, held_h;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] r;
        logic [7:0] m;
        logic       ci;
        logic       si;
        logic [7:0] out;
        logic       co;
        logic       v;
    } alu_vec_t;

    alu_vec_t vecs[12];

    cpu_datapath dut (
        .clk     (clk),
        .RST     (RST),
        .abl_op  (abl_op),
        .abl_ci  (abl_ci),
        .abh_op  (abh_op),
        .abh_ff  (abh_ff),
        .pcl     (pcl),
        .pch     (pch),
        .ahl     (ahl),
        .dbl     (dbl),
        .reg_r   (reg_r),
        .alu_op  (alu_op),
        .alu_ci  (alu_ci),
        .alu_si  (alu_si),
        .alu_m   (alu_m),
        .dec     (dec),
        .abl     (abl),
        .abh     (abh),
        .abl_co  (abl_co),
        .alu_out (alu_out),
        .alu_co  (alu_co),
        .alu_v   (alu_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_addr(input string name, input int exp_l, input int exp_h, input int exp_co);
        check({name, " abl"}, int'(abl), exp_l);
        check({name, " abh"}, int'(abh), exp_h);
        check({name, " abl_co"}, int'(abl_co), exp_co);
    endtask

    // Advance one clock; hold registers capture the address presented before the edge.
    task automatic step(input int exp_l, input int exp_h);
        @(posedge clk);
        held_l = exp_l;
        held_h = exp_h;
        @(negedge clk);
    endtask

    function automatic void alu_model(input int fn, input int srcr, input int r, input int m,
                                      input int ci, input int si,
                                      output int out, output int co, output int v);
        int s, b, src;
        src = srcr ? r : m;
        out = 0; co = 0; v = 0;
        case (fn)
            0: out = r | m;
            1: out = r & m;
            2: out = r ^ m;
            3, 4: begin
                b   = (fn == 4) ? 255 - m : m;
                s   = r + b + ci;
                out = s % 256;
                co  = s / 256;
                // Signed overflow: result falls outside -128..127.
                v   = ((r >= 128 ? r - 256 : r) + (b >= 128 ? b - 256 : b) + ci > 127) ||
                      ((r >= 128 ? r - 256 : r) + (b >= 128 ? b - 256 : b) + ci < -128);
            end
            5: out = m;
            6: begin out = (src * 2 + si) % 256; co = src / 128; end
            default: begin out = src / 2 + si * 128; co = src % 2; end
        endcase
    endfunction

    function automatic void addr_model(input int aop, input int ci, input int hop, input int ff,
                                       output int l, output int h, output int co);
        int base, off, s, hb;
        base = (aop / 4 == 0) ? held_l : (aop / 4 == 1) ? int'(pcl) :
               (aop / 4 == 2) ? int'(ahl) : int'(dbl);
        off  = (aop % 4 == 0) ? 0 : (aop % 4 == 1) ? int'(reg_r) :
               (aop % 4 == 2) ? int'(dbl) : 255;
        s    = base + off + ci;
        l    = s % 256;
        co   = s / 256;
        hb   = (hop % 4 == 0) ? held_h : (hop % 4 == 1) ? int'(pch) :
               (hop % 4 == 2) ? int'(dbl) : 0;
        h    = ff ? 255 : (hb + ((hop / 4 == 1) ? co : 0)) % 256;
    endfunction

    initial begin
        int eo, ec, ev, el, eh, eco;

        vecs[0]  = '{5'b01100, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1}; // ADD overflow
        vecs[1]  = '{5'b10000, 8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0}; // SUB carry
        vecs[2]  = '{5'b11101, 8'h01, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0}; // ROR A
        vecs[3]  = '{5'b00000, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0}; // OR
        vecs[4]  = '{5'b00100, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0}; // AND
        vecs[5]  = '{5'b01000, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0}; // EOR
        vecs[6]  = '{5'b10100, 8'h11, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0}; // PASS
        vecs[7]  = '{5'b11000, 8'h00, 8'h81, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0}; // ASL M
        vecs[8]  = '{5'b01100, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}; // ADD wrap
        vecs[9]  = '{5'b10000, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1}; // SUB overflow
        vecs[10] = '{5'b10000, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0}; // SUB borrow
        vecs[11] = '{5'b11100, 8'hFF, 8'h02, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0}; // LSR M

        RST = 1'b1;
        abl_op = 4'h0; abl_ci = 1'b0; abh_op = 3'h0; abh_ff = 1'b0;
        pcl = 8'h34; pch = 8'h12; ahl = 8'h00; dbl = 8'h00; reg_r = 8'h00;
        alu_op = 5'h0; alu_ci = 1'b0; alu_si = 1'b0; alu_m = 8'h00; dec = 1'b0;
        held_l = 0; held_h = 0;
        #1;
        check_addr("reset hold", 0, 0, 0);
        @(negedge clk);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            alu_op = vecs[i].op; reg_r = vecs[i].r; alu_m = vecs[i].m;
            alu_ci = vecs[i].ci; alu_si = vecs[i].si;
            #1;
            check($sformatf("alu vec%0d out", i), int'(alu_out), int'(vecs[i].out));
            check($sformatf("alu vec%0d co", i), int'(alu_co), int'(vecs[i].co));
            check($sformatf("alu vec%0d v", i), int'(alu_v), int'(vecs[i].v));
        end

        // Decimal add is only honoured when the BCD feature is built in.
        alu_op = 5'b01100; reg_r = 8'h09; alu_m = 8'h01; alu_ci = 1'b0; dec = 1'b1;
        #1;
`ifdef ALU_BCD_EN
        check("bcd add out", int'(alu_out), 'h10);
`else
        check("dec ignored out", int'(alu_out), 'h0A);
`endif
        check("bcd add co", int'(alu_co), 0);
        dec = 1'b0;

        // abs,X page cross
        @(negedge clk);
        abl_op = 4'b1001; ahl = 8'hF0; reg_r = 8'h20; abh_op = 3'b110; dbl = 8'h12;
        #1;
        check_addr("page cross", 'h10, 'h13, 1);
        step('h10, 'h13);

        // PCL + carry-in wrap propagates into PCH
        abl_op = 4'b0100; abl_ci = 1'b1; pcl = 8'hFF; abh_op = 3'b101; pch = 8'h12;
        #1;
        check_addr("pc wrap", 'h00, 'h13, 1);
        step('h00, 'h13);
        abl_ci = 1'b0;

        // Vector fetch then hold
        abh_ff = 1'b1; abl_op = 4'b1100; abh_op = 3'b000; dbl = 8'hFE;
        #1;
        check_addr("vector", 'hFE, 'hFF, 0);
        step('hFE, 'hFF);
        abh_ff = 1'b0; abl_op = 4'b0000;
        #1;
        check_addr("vector hold", 'hFE, 'hFF, 0);

        // Asynchronous reset mid-run, clock low
        RST = 1'b1;
        #1;
        check_addr("async reset", 0, 0, 0);
        held_l = 0; held_h = 0;
        #1;
        RST = 1'b0;
        step(0, 0);
        #1;
        check_addr("post reset hold", 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            abl_op = 4'($urandom); abl_ci = 1'($urandom); abh_op = 3'($urandom);
            abh_ff = ($urandom_range(0, 7) == 0);
            pcl = 8'($urandom); pch = 8'($urandom); ahl = 8'($urandom);
            dbl = 8'($urandom); reg_r = 8'($urandom);
            alu_op = {3'($urandom), 1'b0, 1'($urandom)};
            alu_ci = 1'($urandom); alu_si = 1'($urandom); alu_m = 8'($urandom);
            #1;
            addr_model(int'(abl_op), int'(abl_ci), int'(abh_op), int'(abh_ff), el, eh, eco);
            check_addr($sformatf("rand%0d", i), el, eh, eco);
            alu_model(int'(alu_op[4:2]), int'(alu_op[0]), int'(reg_r), int'(alu_m),
                      int'(alu_ci), int'(alu_si), eo, ec, ev);
            check($sformatf("rand%0d alu_out", i), int'(alu_out), eo);
            check($sformatf("rand%0d alu_co", i), int'(alu_co), ec);
            check($sformatf("rand%0d alu_v", i), int'(alu_v), ev);
            step(el, eh);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
